imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder_if.sv | 22 ++
 rtl/imem_responder.sv | 45 ++++
 tb/tb_imem_responder.sv | 116 +++++++++++
 3 files changed

// File: rtl/imem_responder_if.sv
// imem_responder_if: fetch request/response, flush and program-load signals.
interface imem_responder_if #(parameter int AW = 10);
   logic          req_valid;
   logic          req_ready;
   logic [31:0]   req_addr;
   logic          flush;
   logic          resp_valid;
   logic          resp_ready;
   logic [31:0]   resp_instr;
   logic          resp_err;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [31:0]   wr_data;
   modport slave (
      input  req_valid, req_addr, flush, resp_ready, wr_en, wr_addr, wr_data,
      output req_ready, resp_valid, resp_instr, resp_err
   );
   modport master (
      output req_valid, req_addr, flush, resp_ready, wr_en, wr_addr, wr_data,
      input  req_ready, resp_valid, resp_instr, resp_err
   );
endinterface

// File: rtl/imem_responder.sv
// imem_responder: word-addressed instruction memory feeding a 2-entry response FIFO.
module imem_responder #(
   parameter int          DEPTH    = 1024,
   parameter logic [31:0] NOP_WORD = 32'h0000_0013,
   localparam int         AW       = $clog2(DEPTH)
) (
   input logic             clk,
   input logic             rst,
   imem_responder_if.slave bus
);
   logic [31:0] mem [DEPTH];
   logic [31:0] data [2];
   logic        err [2];
   logic [1:0]  count;
   logic        wp, rp, push, pop, oor;
   always_comb begin
      oor            = bus.req_addr >= 32'(DEPTH);
      bus.req_ready  = count != 2'd2;
      bus.resp_valid = count != 2'd0;
      push           = bus.req_valid && count != 2'd2;
      pop            = count != 2'd0 && bus.resp_ready && !bus.flush;
      bus.resp_instr = count != 2'd0 ? data[rp] : 32'd0;
      bus.resp_err   = count != 2'd0 && err[rp];
   end
   // Flush drops everything already queued; a push on the same edge lands at the new head.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= 2'd0;
         wp    <= 1'b0;
         rp    <= 1'b0;
      end else begin
         count <= bus.flush ? {1'b0, push} : count + {1'b0, push} - {1'b0, pop};
         wp    <= wp ^ push;
         rp    <= bus.flush ? wp : rp ^ pop;
      end
   end
   // Storage is never reset; the fetch reads mem before this edge's write lands.
   always_ff @(posedge clk) begin
      if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
      if (push) begin
         data[wp] <= oor ? NOP_WORD : mem[bus.req_addr[AW-1:0]];
         err[wp]  <= oor;
      end
   end
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed and random fetch traffic against a queue-based reference model.
module tb_imem_responder;
   typedef struct {logic [31:0] instr; logic err;} rsp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int total = 0;
   int bad = 0;
   rsp_t q[$];
   logic [31:0] mm [16];
   imem_responder_if #(.AW(10)) bus();
   imem_responder dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic check_all(string tag);
      chk({tag, ".req_ready"}, {31'd0, bus.req_ready}, {31'd0, q.size() < 2});
      chk({tag, ".resp_valid"}, {31'd0, bus.resp_valid}, {31'd0, q.size() != 0});
      chk({tag, ".resp_instr"}, bus.resp_instr, q.size() != 0 ? q[0].instr : 32'd0);
      chk({tag, ".resp_err"}, {31'd0, bus.resp_err}, {31'd0, q.size() != 0 && q[0].err});
   endtask
   task automatic cycle(string tag);
      bit acc, pp;
      rsp_t e;
      acc = bus.req_valid && q.size() < 2;
      pp = bus.resp_ready && q.size() != 0 && !bus.flush;
      e.err = bus.req_addr >= 32'd1024;
      e.instr = e.err ? 32'h0000_0013 : mm[bus.req_addr[3:0]];
      @(posedge clk);
      if (bus.flush) q.delete();
      else if (pp) void'(q.pop_front());
      if (acc) q.push_back(e);
      if (bus.wr_en) mm[bus.wr_addr[3:0]] = bus.wr_data;
      #1;
      check_all(tag);
   endtask
   task automatic drive(string tag, bit v, logic [31:0] a, bit rr, bit fl,
                        bit we, logic [9:0] wa, logic [31:0] wd);
      bus.req_valid = v;
      bus.req_addr = a;
      bus.resp_ready = rr;
      bus.flush = fl;
      bus.wr_en = we;
      bus.wr_addr = wa;
      bus.wr_data = wd;
      cycle(tag);
   endtask
   initial begin
      drive_idle();
      #1;
      check_all("reset");
      #2 rst = 1'b0;
      for (int i = 0; i < 16; i++) drive("load", 0, 0, 0, 0, 1, 10'(i), $urandom);
      drive("load1", 0, 0, 0, 0, 1, 10'd1, 32'h0015_8593);
      drive("load2", 0, 0, 0, 0, 1, 10'd2, 32'h0204_0293);
      drive("load4", 0, 0, 0, 0, 1, 10'd4, 32'hAAAA_AAAA);
      drive("fetch1", 1, 1, 1, 0, 0, 0, 0);
      chk("fetch1.instr", bus.resp_instr, 32'h0015_8593);
      drive("fetch2", 1, 2, 1, 0, 0, 0, 0);
      chk("fetch2.instr", bus.resp_instr, 32'h0204_0293);
      drive("drain", 0, 0, 1, 0, 0, 0, 0);
      drive("bp1", 1, 1, 0, 0, 0, 0, 0);
      drive("bp2", 1, 2, 0, 0, 0, 0, 0);
      chk("bp.full", {31'd0, bus.req_ready}, 32'd0);
      drive("bp3", 1, 3, 0, 0, 0, 0, 0);
      drive("bp_pop", 1, 3, 1, 0, 0, 0, 0);
      drive("bp_acc3", 1, 3, 1, 0, 0, 0, 0);
      drive("bp_drain", 0, 0, 1, 0, 0, 0, 0);
      drive("bp_drain", 0, 0, 1, 0, 0, 0, 0);
      drive("oor1024", 1, 32'd1024, 1, 0, 0, 0, 0);
      chk("oor1024.err", {31'd0, bus.resp_err}, 32'd1);
      drive("oor_max", 1, 32'hFFFF_FFFF, 1, 0, 0, 0, 0);
      chk("oor_max.instr", bus.resp_instr, 32'h0000_0013);
      drive("oor_drain", 0, 0, 1, 0, 0, 0, 0);
      drive("fl_a", 1, 1, 0, 0, 0, 0, 0);
      drive("fl_b", 1, 2, 0, 0, 0, 0, 0);
      drive("fl_pop", 0, 0, 1, 0, 0, 0, 0);
      drive("flush", 1, 5, 1, 1, 0, 0, 0);
      chk("flush.instr", bus.resp_instr, mm[5]);
      drive("flush_pop", 0, 0, 1, 0, 0, 0, 0);
      drive("coll", 1, 4, 1, 0, 1, 10'd4, 32'h5555_5555);
      chk("coll.old", bus.resp_instr, 32'hAAAA_AAAA);
      drive("coll_new", 1, 4, 1, 0, 0, 0, 0);
      chk("coll.new", bus.resp_instr, 32'h5555_5555);
      drive("ar_a", 1, 1, 0, 0, 0, 0, 0);
      drive("ar_b", 1, 2, 0, 0, 0, 0, 0);
      drive_idle();
      #3 rst = 1'b1;
      #1;
      q.delete();
      check_all("async_rst");
      rst = 1'b0;
      drive("post_rst", 1, 2, 1, 0, 0, 0, 0);
      chk("post_rst.instr", bus.resp_instr, 32'h0204_0293);
      for (int i = 0; i < 400; i++)
         drive("rand", $urandom_range(0, 3) != 0,
               $urandom_range(0, 9) == 0 ? ($urandom | 32'h400) : 32'($urandom_range(0, 15)),
               $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
               $urandom_range(0, 3) == 0, 10'($urandom_range(0, 15)), $urandom);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
   task automatic drive_idle();
      bus.req_valid = 1'b0;
      bus.req_addr = 32'd0;
      bus.resp_ready = 1'b0;
      bus.flush = 1'b0;
      bus.wr_en = 1'b0;
      bus.wr_addr = 10'd0;
      bus.wr_data = 32'd0;
   endtask
endmodule
